// File: rtl/serial_word_rx.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits, stop bit, one bit per SER_EN strobe.
// Optional even-parity bit between data and stop when RX_PARITY_EN is defined.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SER_EN,
  input  logic             SER,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  output logic             BUSY,
`ifdef RX_PARITY_EN
  output logic             PAR_ERR,
`endif
  output logic             FRAME_ERR
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd2, S_PARITY = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_STOP = 2'd2} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sbuf_q, sbuf_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             par_bad_q, par_bad_d;
  logic [WIDTH-1:0] shifted_c;

  // Placement of the incoming bit decides which end of Q the first data bit lands on
  assign shifted_c = MSB_FIRST ? {sbuf_q[WIDTH-2:0], SER} : {SER, sbuf_q[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sbuf_q    <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sbuf_q    <= sbuf_d;
      q_q       <= q_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      par_bad_q <= par_bad_d;
    end
  end

`ifdef RX_PARITY_EN
  logic perr_q, perr_d;

  always_ff @(posedge CLK) begin
    if (CLR) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign PAR_ERR = perr_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sbuf_d    = sbuf_q;
    q_d       = q_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    ferr_d    = 1'b0;
    par_bad_d = par_bad_q;
`ifdef RX_PARITY_EN
    perr_d    = 1'b0;
`endif
    if (SER_EN) begin
      case (state_q)
        S_IDLE: begin
          if (!SER) begin
            state_d   = S_DATA;
            cnt_d     = '0;
            busy_d    = 1'b1;
            par_bad_d = 1'b0;
          end
        end
        S_DATA: begin
          sbuf_d = shifted_c;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        S_PARITY: begin
          par_bad_d = (^sbuf_q) ^ SER;
          state_d   = S_STOP;
        end
`endif
        S_STOP: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (!SER) begin
            ferr_d = 1'b1;
          end else if (!par_bad_q) begin
            q_d     = sbuf_q;
            valid_d = 1'b1;
          end
`ifdef RX_PARITY_EN
          perr_d = par_bad_q;
`endif
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign Q         = q_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: MSB-first and LSB-first receivers share one serial line;
// expected words go into per-receiver queues and are popped whenever VALID pulses.
module tb_serial_word_rx;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       SER_EN;
  logic       SER;
  logic [3:0] q_m, q_l;
  logic       valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l;
`ifdef RX_PARITY_EN
  logic       perr_m, perr_l;
`endif

  int unsigned tests  = 0;
  int unsigned failed = 0;

  logic [3:0] exp_m_q[$];
  logic [3:0] exp_l_q[$];
  logic [3:0] last_m, last_l;

  always #5 CLK = ~CLK;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .CLR(CLR), .SER_EN(SER_EN), .SER(SER),
    .Q(q_m), .VALID(valid_m), .BUSY(busy_m),
`ifdef RX_PARITY_EN
    .PAR_ERR(perr_m),
`endif
    .FRAME_ERR(ferr_m)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .CLR(CLR), .SER_EN(SER_EN), .SER(SER),
    .Q(q_l), .VALID(valid_l), .BUSY(busy_l),
`ifdef RX_PARITY_EN
    .PAR_ERR(perr_l),
`endif
    .FRAME_ERR(ferr_l)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clk_step(input logic ser, input logic en);
    SER    = ser;
    SER_EN = en;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = d[3-i];
    return r;
  endfunction

  // Pops the scoreboard on a VALID pulse and checks Q against it
  task automatic scoreboard_pop();
    if (valid_m) begin
      if (exp_m_q.size() == 0) chk("msb_unexpected_valid", 16'(valid_m), 16'd0);
      else chk("msb_q", 16'(q_m), 16'(exp_m_q.pop_front()));
    end
    if (valid_l) begin
      if (exp_l_q.size() == 0) chk("lsb_unexpected_valid", 16'(valid_l), 16'd0);
      else chk("lsb_q", 16'(q_l), 16'(exp_l_q.pop_front()));
    end
  endtask

  // d[3] is the first data bit on the line
  task automatic send_word(input logic [3:0] d, input logic stop_ok, input logic par_flip,
                           input logic gaps);
    logic bits[$];
    logic good;
    int   n;
    bits.push_back(1'b0);
    for (int i = 3; i >= 0; i--) bits.push_back(d[i]);
`ifdef RX_PARITY_EN
    bits.push_back((^d) ^ par_flip);
    good = stop_ok && !par_flip;
`else
    good = stop_ok;
`endif
    bits.push_back(stop_ok);
    if (good) begin
      exp_m_q.push_back(d);
      exp_l_q.push_back(rev4(d));
      last_m = d;
      last_l = rev4(d);
    end
    n = bits.size();
    for (int i = 0; i < n; i++) begin
      clk_step(bits[i], 1'b1);
      chk("busy", 16'({busy_m, busy_l}), (i < n - 1) ? 16'h3 : 16'h0);
      chk("valid", 16'({valid_m, valid_l}), (i == n - 1 && good) ? 16'h3 : 16'h0);
      chk("frame_err", 16'({ferr_m, ferr_l}), (i == n - 1 && !stop_ok) ? 16'h3 : 16'h0);
`ifdef RX_PARITY_EN
      chk("par_err", 16'({perr_m, perr_l}), (i == n - 1 && par_flip) ? 16'h3 : 16'h0);
`endif
      chk("valid_ferr_excl", 16'(valid_m & ferr_m), 16'd0);
      scoreboard_pop();
      if (gaps) begin
        clk_step(~bits[i], 1'b0);
        chk("gap_busy", 16'(busy_m), (i < n - 1) ? 16'h1 : 16'h0);
        chk("gap_pulses", 16'({valid_m, ferr_m, valid_l, ferr_l}), 16'h0);
      end
    end
    chk("q_hold_msb", 16'(q_m), 16'(last_m));
    chk("q_hold_lsb", 16'(q_l), 16'(last_l));
  endtask

  initial begin
    last_m = 4'h0;
    last_l = 4'h0;
    CLR    = 1'b1;
    SER    = 1'b1;
    SER_EN = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("reset_q", 16'({q_m, q_l}), 16'h00);
    chk("reset_flags", 16'({valid_m, busy_m, ferr_m, valid_l, busy_l, ferr_l}), 16'h0);

    // Idle line: nothing should start
    for (int i = 0; i < 5; i++) begin
      clk_step(1'b1, 1'b1);
      chk("idle_flags", 16'({q_m, valid_m, busy_m, ferr_m}), 16'h0);
    end

    send_word(4'b1010, 1'b1, 1'b0, 1'b0);
    send_word(4'b1010, 1'b1, 1'b0, 1'b1);
    send_word(4'b1100, 1'b0, 1'b0, 1'b0);
    // Line still low after the bad stop: next edge is a start bit
    send_word(4'b0011, 1'b1, 1'b0, 1'b0);

    // Mid-frame reset discards the partial frame and clears Q
    clk_step(1'b0, 1'b1);
    clk_step(1'b1, 1'b1);
    clk_step(1'b1, 1'b1);
    chk("midframe_busy", 16'(busy_m), 16'h1);
    CLR = 1'b1;
    clk_step(1'b1, 1'b1);
    CLR = 1'b0;
    last_m = 4'h0;
    last_l = 4'h0;
    chk("clr_busy", 16'({busy_m, busy_l}), 16'h0);
    chk("clr_q", 16'({q_m, q_l}), 16'h00);
    send_word(4'b1100, 1'b1, 1'b0, 1'b0);

    // Back-to-back frames and an LSB-first boundary word
    send_word(4'b1000, 1'b1, 1'b0, 1'b0);
    send_word(4'b1111, 1'b1, 1'b0, 1'b0);
    send_word(4'b0000, 1'b1, 1'b0, 1'b1);

`ifdef RX_PARITY_EN
    send_word(4'b1010, 1'b1, 1'b0, 1'b0);
    send_word(4'b1011, 1'b1, 1'b1, 1'b0);
    send_word(4'b1000, 1'b1, 1'b0, 1'b0);
    send_word(4'b0110, 1'b0, 1'b1, 1'b0);
`endif

    clk_step(1'b1, 1'b1);
    chk("sb_drain_msb", 16'(exp_m_q.size()), 16'd0);
    chk("sb_drain_lsb", 16'(exp_l_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Serial-to-parallel frame receiver; the far end of a link driven by our universal shift register (4-bit, right/left shift, SER out).
- Samples a framed serial stream (start bit, WIDTH data bits, stop bit), one bit per enabled clock.
- Presents the word on a parallel port with a one-cycle valid strobe.
- Flags framing errors; the last good word is held otherwise.

Parameters:
- WIDTH, 4, data bits per frame (2..16).
- MSB_FIRST, 1, 1: first data bit received goes to Q[WIDTH-1]; 0: first data bit received goes to Q[0].

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- CLR  input  1  synchronous, active-high reset.
- SER_EN  input  1  bit strobe; SER is sampled only on edges where SER_EN=1.
- SER  input  1  serial data line; idles high.
- Q  output  WIDTH  last correctly received word.
- VALID  output  1  one-cycle pulse: Q was updated on this edge.
- BUSY  output  1  high from the accepted start bit until the frame completes.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (CLR=1 at an edge): state IDLE, Q=0, VALID=0, BUSY=0, FRAME_ERR=0, bit counter=0, shift buffer=0. CLR has priority over everything, including mid-frame; the partial frame is discarded.
- Only edges with SER_EN=1 advance the FSM or the shift buffer. With SER_EN=0 all state holds, and VALID/FRAME_ERR return to 0.
- FSM:
  - IDLE: SER=0 sampled -> DATA, counter=0, BUSY=1. SER=1 -> stay.
  - DATA: shift SER into the buffer per MSB_FIRST, counter+1. After WIDTH bits -> STOP (PARITY when the option is on).
  - STOP: SER=1 -> Q<=buffer, VALID=1. SER=0 -> FRAME_ERR=1, Q unchanged. Either case -> IDLE, BUSY=0.
- Latency: VALID and Q change on the same edge that samples the stop bit, i.e. visible in the cycle after that edge.
- VALID and FRAME_ERR are never high together; each is high exactly one CLK cycle.
- Back-to-back frames: a start bit may be sampled on the next enabled edge after the stop bit; no gap is required.
- Low SER in IDLE is always a start bit. After a framing error, a line that stays low starts a new frame on the next enabled edge.
- Buffer shifts inside the full WIDTH field; counter width is clog2(WIDTH+1). The counter never wraps mid-frame.

Optional Feature:
- Macro RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, with even parity (XOR of data bits and parity bit = 0).
  - Adds output PAR_ERR (1 bit), a one-cycle pulse on the stop-bit edge when parity mismatched. Q is not updated and VALID stays 0.
  - A frame with both a stop error and a parity error pulses FRAME_ERR and PAR_ERR together.
- Undefined: no PARITY state, no PAR_ERR port; the frame is start + WIDTH data bits + stop.

Test Plan:
1. CLR=1 for 1 cycle, then SER=1, SER_EN=1 for 5 cycles -> Q=0000, BUSY=0, VALID=0 throughout.
2. WIDTH=4, MSB_FIRST=1, SER_EN=1 continuous, SER sequence 0,1,0,1,0,1 -> BUSY high 5 cycles; Q=1010 and VALID one pulse after the 6th edge.
3. Same frame with SER_EN toggling 1,0,1,0,... -> same Q=1010, VALID one pulse; the result depends only on enabled edges.
4. Frame 0,1,1,0,0,0 (bad stop) after a good 1010 -> FRAME_ERR one pulse, Q stays 1010, VALID=0. Then 0,0,0,1,1,1 -> Q=0011 with VALID.
5. Mid-frame reset: start bit plus 2 data bits, then CLR=1 one cycle -> BUSY=0, Q=0000. Next full frame 0,1,1,0,0,1 -> Q=1100 with VALID.
6. RX_PARITY_EN: frame 0,1,0,1,0,[p=0],1 -> Q=1010, VALID. Frame 0,1,0,1,1,[p=0],1 -> PAR_ERR pulse, Q stays 1010. MSB_FIRST=0 with frame 0,1,0,0,0,[p=1],1 -> Q=0001.
